timer_ctrl: RTL and testbench

//   Timer/counter engine for the 8051 core. It sequences Timer0 and Timer1 (TL0/TH0/TL1/TH1) according to the

---
 rtl/timer_ctrl_pkg.sv | 76 +++++++
 rtl/timer_ctrl_pin_sync.sv | 52 +++++
 rtl/timer_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// timer_ctrl_pkg
//   Shared definitions for the 8051 timer/counter engine: SFR addresses of the four count
//   registers, TMOD mode encodings, a decoded TMOD nibble, and the common counting step used
//   by both timers.
// ---------------------------------------------------------------------------------------------
package timer_ctrl_pkg;

    // Count-register SFR addresses
    localparam logic [7:0] SFR_TL0 = 8'h8A;
    localparam logic [7:0] SFR_TL1 = 8'h8B;
    localparam logic [7:0] SFR_TH0 = 8'h8C;
    localparam logic [7:0] SFR_TH1 = 8'h8D;

    typedef enum logic [1:0] {
        MODE_13B    = 2'b00,
        MODE_16B    = 2'b01,
        MODE_RELOAD = 2'b10,
        MODE_SPLIT  = 2'b11
    } timer_mode_e;

    // One TMOD nibble: [3]GATE [2]C/T [1:0]M
    typedef struct packed {
        logic        gate;
        logic        c_t;
        timer_mode_e mode;
    } tmod_cfg_t;

    // Result of one count step on a {TH,TL} pair
    typedef struct packed {
        logic [7:0] th;
        logic [7:0] tl;
        logic       ovf;
    } timer_step_t;

    // Next value of a timer for one increment in the given mode. MODE_SPLIT is not a counting
    // mode for the shared path: the value holds and no overflow is reported.
    function automatic timer_step_t timer_step(input timer_mode_e mode,
                                               input logic [7:0]  tl,
                                               input logic [7:0]  th);
        timer_step_t r;
        logic [12:0] c13;
        logic [15:0] c16;
        r.tl  = tl;
        r.th  = th;
        r.ovf = 1'b0;
        c13   = {th, tl[4:0]} + 13'd1;
        c16   = {th, tl} + 16'd1;
        case (mode)
            MODE_13B: begin
                // TL[7:5] is not part of the 13-bit count and keeps its value
                r.th  = c13[12:5];
                r.tl  = {tl[7:5], c13[4:0]};
                r.ovf = &{th, tl[4:0]};
            end
            MODE_16B: begin
                r.th  = c16[15:8];
                r.tl  = c16[7:0];
                r.ovf = &{th, tl};
            end
            MODE_RELOAD: begin
                if (tl == 8'hFF) begin
                    r.tl  = th;
                    r.ovf = 1'b1;
                end else begin
                    r.tl = tl + 8'd1;
                end
            end
            default: begin
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/timer_ctrl_pin_sync.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// timer_pin_sync
//   Two-flop synchroniser for an asynchronous pin, plus a falling-edge detector that samples
//   only on prescaler ticks (so a count needs the pin high on one tick and low on a later one).
//   Ports:
//     clock    in  system clock
//     reset    in  asynchronous active-high reset; all flops reset to 1 (idle-high pin)
//     tick     in  prescaler tick
//     pin_in   in  asynchronous pin
//     pin_out  out EDGE_DETECT=1: one-tick falling-edge event; EDGE_DETECT=0: synchronised level
// ---------------------------------------------------------------------------------------------
module timer_pin_sync #(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic pin_in,
    output logic pin_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic last_q, last_d;
    logic fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            last_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        meta_d = pin_in;
        sync_d = meta_q;
        last_d = last_q;
        if (tick) begin
            last_d = sync_q;
        end
    end

    assign fall    = tick & last_q & ~sync_q;
    assign pin_out = EDGE_DETECT ? fall : sync_q;

endmodule

// File: rtl/timer_ctrl.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------------------------
// timer_ctrl
//   8051 Timer0/Timer1 engine. Owns TL0/TH0/TL1/TH1, runs them from a machine-cycle prescaler
//   according to TMOD and the TR0/TR1 run bits, and emits registered one-clock overflow pulses
//   towards TCON (tf0_set/tf1_set) and the UART baud logic (t1_ovf).
//   Ports:
//     clock, reset          system clock; asynchronous active-high reset
//     data_in, addr         SFR write data and address
//     wr_en, wr_bit_en      write strobe; byte writes need wr_en & !wr_bit_en
//     tmod_data             TMOD: [7]GATE1 [6]C/T1 [5:4]M1 [3]GATE0 [2]C/T0 [1:0]M0
//     tr0, tr1              TCON run bits
//     int0, int1            external interrupt pins (gating), asynchronous
//     t0, t1                external count pins, asynchronous
//     tl0, th0, tl1, th1    count registers
//     tf0_set, tf1_set      overflow pulses to TCON
//     t1_ovf                Timer1 overflow pulse in every mode
// ---------------------------------------------------------------------------------------------
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic [7:0] addr,
    input  logic       wr_en,
    input  logic       wr_bit_en,
    input  logic [7:0] tmod_data,
    input  logic       tr0,
    input  logic       tr1,
    input  logic       int0,
    input  logic       int1,
    input  logic       t0,
    input  logic       t1,
    output logic [7:0] tl0,
    output logic [7:0] th0,
    output logic [7:0] tl1,
    output logic [7:0] th1,
    output logic       tf0_set,
    output logic       tf1_set,
    output logic       t1_ovf
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // -----------------------------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------------------------
    logic [PsW-1:0] ps_q, ps_d;
    logic           tick;

    assign tick = (ps_q == PsW'(PRESCALE - 1));

    always_comb begin
        ps_d = ps_q + PsW'(1);
        if (tick) begin
            ps_d = '0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Pin synchronisers
    // -----------------------------------------------------------------------------------------
    logic t0_fall, t1_fall, int0_lvl, int1_lvl;

    timer_pin_sync #(.EDGE_DETECT(1'b1)) u_sync_t0 (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .pin_in  (t0),
        .pin_out (t0_fall)
    );

    timer_pin_sync #(.EDGE_DETECT(1'b1)) u_sync_t1 (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .pin_in  (t1),
        .pin_out (t1_fall)
    );

    timer_pin_sync #(.EDGE_DETECT(1'b0)) u_sync_int0 (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .pin_in  (int0),
        .pin_out (int0_lvl)
    );

    timer_pin_sync #(.EDGE_DETECT(1'b0)) u_sync_int1 (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .pin_in  (int1),
        .pin_out (int1_lvl)
    );

    // -----------------------------------------------------------------------------------------
    // Configuration and enables
    // -----------------------------------------------------------------------------------------
    tmod_cfg_t cfg0, cfg1;
    logic      t0_split;
    logic      byte_wr;
    logic      wr_tl0, wr_th0, wr_tl1, wr_th1;
    logic      run0, run1;
    logic      inc0, inc1, th0_inc;

    assign cfg0     = tmod_cfg_t'(tmod_data[3:0]);
    assign cfg1     = tmod_cfg_t'(tmod_data[7:4]);
    assign t0_split = (cfg0.mode == MODE_SPLIT);

    assign byte_wr = wr_en & ~wr_bit_en;
    assign wr_tl0  = byte_wr & (addr == SFR_TL0);
    assign wr_th0  = byte_wr & (addr == SFR_TH0);
    assign wr_tl1  = byte_wr & (addr == SFR_TL1);
    assign wr_th1  = byte_wr & (addr == SFR_TH1);

    assign run0 = tr0 & (~cfg0.gate | int0_lvl);
    // With Timer0 split, TR1 belongs to TH0, so Timer1 runs on its gate condition alone
    assign run1 = (t0_split | tr1) & (~cfg1.gate | int1_lvl);

    assign inc0    = run0 & tick & (cfg0.c_t ? t0_fall : 1'b1);
    assign inc1    = run1 & tick & (cfg1.c_t ? t1_fall : 1'b1);
    assign th0_inc = tick & tr1;

    // -----------------------------------------------------------------------------------------
    // Timer0
    // -----------------------------------------------------------------------------------------
    logic [7:0]  tl0_q, tl0_d, th0_q, th0_d;
    logic        ovf0, ovf_th0;
    timer_step_t step0;

    always_comb begin
        tl0_d   = tl0_q;
        th0_d   = th0_q;
        ovf0    = 1'b0;
        ovf_th0 = 1'b0;
        step0   = timer_step(cfg0.mode, tl0_q, th0_q);
        if (t0_split) begin
            // Two independent 8-bit halves; a write only blocks the half it targets
            if (wr_tl0) begin
                tl0_d = data_in;
            end else if (inc0) begin
                tl0_d = tl0_q + 8'd1;
                ovf0  = (tl0_q == 8'hFF);
            end
            if (wr_th0) begin
                th0_d = data_in;
            end else if (th0_inc) begin
                th0_d   = th0_q + 8'd1;
                ovf_th0 = (th0_q == 8'hFF);
            end
        end else if (wr_tl0 || wr_th0) begin
            if (wr_tl0) begin
                tl0_d = data_in;
            end
            if (wr_th0) begin
                th0_d = data_in;
            end
        end else if (inc0) begin
            tl0_d = step0.tl;
            th0_d = step0.th;
            ovf0  = step0.ovf;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Timer1 (mode 3 holds: timer_step returns the value unchanged with no overflow)
    // -----------------------------------------------------------------------------------------
    logic [7:0]  tl1_q, tl1_d, th1_q, th1_d;
    logic        ovf1;
    timer_step_t step1;

    always_comb begin
        tl1_d = tl1_q;
        th1_d = th1_q;
        ovf1  = 1'b0;
        step1 = timer_step(cfg1.mode, tl1_q, th1_q);
        if (wr_tl1 || wr_th1) begin
            if (wr_tl1) begin
                tl1_d = data_in;
            end
            if (wr_th1) begin
                th1_d = data_in;
            end
        end else if (inc1) begin
            tl1_d = step1.tl;
            th1_d = step1.th;
            ovf1  = step1.ovf;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Overflow pulses
    // -----------------------------------------------------------------------------------------
    logic tf0_set_q, tf0_set_d;
    logic tf1_set_q, tf1_set_d;
    logic t1_ovf_q, t1_ovf_d;

    always_comb begin
        tf0_set_d = ovf0;
        tf1_set_d = t0_split ? ovf_th0 : ovf1;
        t1_ovf_d  = ovf1;
    end

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_q      <= '0;
            tl0_q     <= 8'h00;
            th0_q     <= 8'h00;
            tl1_q     <= 8'h00;
            th1_q     <= 8'h00;
            tf0_set_q <= 1'b0;
            tf1_set_q <= 1'b0;
            t1_ovf_q  <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            tl0_q     <= tl0_d;
            th0_q     <= th0_d;
            tl1_q     <= tl1_d;
            th1_q     <= th1_d;
            tf0_set_q <= tf0_set_d;
            tf1_set_q <= tf1_set_d;
            t1_ovf_q  <= t1_ovf_d;
        end
    end

    assign tl0     = tl0_q;
    assign th0     = th0_q;
    assign tl1     = tl1_q;
    assign th1     = th1_q;
    assign tf0_set = tf0_set_q;
    assign tf1_set = tf1_set_q;
    assign t1_ovf  = t1_ovf_q;

endmodule

// File: tb/tb_timer_ctrl.sv
`timescale 1ns / 1ps
// Bench for timer_ctrl: table of SFR-write / run-for-N-ticks steps with expected registers and
// pulse counts, plus hand sequences for pin gating, write-on-tick and mid-count reset.
module tb_timer_ctrl;
    import timer_ctrl_pkg::*;

    localparam int PS = 12;

    logic       clock, reset;
    logic [7:0] data_in, addr, tmod_data;
    logic       wr_en, wr_bit_en, tr0, tr1, int0, int1, t0, t1;
    logic [7:0] tl0, th0, tl1, th1;
    logic       tf0_set, tf1_set, t1_ovf;

    timer_ctrl #(.PRESCALE(PS)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .addr      (addr),
        .wr_en     (wr_en),
        .wr_bit_en (wr_bit_en),
        .tmod_data (tmod_data),
        .tr0       (tr0),
        .tr1       (tr1),
        .int0      (int0),
        .int1      (int1),
        .t0        (t0),
        .t1        (t1),
        .tl0       (tl0),
        .th0       (th0),
        .tl1       (tl1),
        .th1       (th1),
        .tf0_set   (tf0_set),
        .tf1_set   (tf1_set),
        .t1_ovf    (t1_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Clock edges since reset release; the expected tick edges are multiples of PS
    int cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pulse monitor, sampled on the falling edge
    int   n_tf0 = 0, n_tf1 = 0, n_ovf = 0, n_dbl = 0;
    logic p_tf0 = 1'b0, p_tf1 = 1'b0, p_ovf = 1'b0;
    always @(negedge clock) begin
        if (tf0_set) n_tf0++;
        if (tf1_set) n_tf1++;
        if (t1_ovf)  n_ovf++;
        if ((tf0_set & p_tf0) | (tf1_set & p_tf1) | (t1_ovf & p_ovf)) n_dbl++;
        p_tf0 = tf0_set;
        p_tf1 = tf1_set;
        p_ovf = t1_ovf;
    end

    typedef struct {
        string      name;
        logic [7:0] tl0, th0, tl1, th1;
        int         d_tf0, d_tf1, d_ovf;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] tmod;
        logic       tr0, tr1, has_wr;
        logic [7:0] waddr, wdata;
        int         n_ticks;
        logic [7:0] tl0, th0, tl1, th1;
        int         d_tf0, d_tf1, d_ovf;
    } step_t;

    exp_t sb_q[$];
    int   checks = 0, errors = 0;
    int   s_tf0, s_tf1, s_ovf;

    task automatic snap();
        s_tf0 = n_tf0;
        s_tf1 = n_tf1;
        s_ovf = n_ovf;
    endtask

    task automatic push(input string name, input logic [7:0] e_tl0, input logic [7:0] e_th0,
                        input logic [7:0] e_tl1, input logic [7:0] e_th1,
                        input int f0, input int f1, input int ov);
        exp_t e;
        e.name  = name;
        e.tl0   = e_tl0;
        e.th0   = e_th0;
        e.tl1   = e_tl1;
        e.th1   = e_th1;
        e.d_tf0 = f0;
        e.d_tf1 = f1;
        e.d_ovf = ov;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        int   a0, a1, a2;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, required 1");
            return;
        end
        e  = sb_q.pop_front();
        a0 = n_tf0 - s_tf0;
        a1 = n_tf1 - s_tf1;
        a2 = n_ovf - s_ovf;
        if (tl0 !== e.tl0 || th0 !== e.th0 || tl1 !== e.tl1 || th1 !== e.th1 ||
            a0 != e.d_tf0 || a1 != e.d_tf1 || a2 != e.d_ovf) begin
            errors++;
            $display({"FAIL %s: got tl0=%h th0=%h tl1=%h th1=%h tf0=%0d tf1=%0d ovf=%0d, ",
                      "required tl0=%h th0=%h tl1=%h th1=%h tf0=%0d tf1=%0d ovf=%0d"},
                     e.name, tl0, th0, tl1, th1, a0, a1, a2,
                     e.tl0, e.th0, e.tl1, e.th1, e.d_tf0, e.d_tf1, e.d_ovf);
        end
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    // Advance through n tick edges; afterwards the last edge passed was a tick edge
    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int g;
            g = 0;
            do begin
                clk1();
                g++;
            end while ((cyc % PS) != 0 && g < PS + 1);
        end
    endtask

    // Byte write on the next edge, moved off a tick edge
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        if ((cyc % PS) == PS - 1) clk1();
        addr    = a;
        data_in = d;
        wr_en   = 1'b1;
        clk1();
        wr_en   = 1'b0;
    endtask

    task automatic t0_pulse();
        t0 = 1'b0;
        wait_ticks(2);
        t0 = 1'b1;
        wait_ticks(2);
    endtask

    task automatic apply_step(input step_t s);
        if ((cyc % PS) == PS - 1) clk1();
        snap();
        tmod_data = s.tmod;
        tr0       = s.tr0;
        tr1       = s.tr1;
        if (s.has_wr) do_write(s.waddr, s.wdata);
        push(s.name, s.tl0, s.th0, s.tl1, s.th1, s.d_tf0, s.d_tf1, s.d_ovf);
        if (s.n_ticks > 0) begin
            wait_ticks(s.n_ticks);
            clk1();  // let the registered pulse appear and be sampled
        end
        check_out();
    endtask

    function automatic step_t mk(input string name, input logic [7:0] tmod, input logic r0,
                                 input logic r1, input logic w, input logic [7:0] wa,
                                 input logic [7:0] wd, input int n, input logic [7:0] e_tl0,
                                 input logic [7:0] e_th0, input logic [7:0] e_tl1,
                                 input logic [7:0] e_th1, input int f0, input int f1,
                                 input int ov);
        step_t s;
        s.name = name; s.tmod = tmod; s.tr0 = r0; s.tr1 = r1; s.has_wr = w;
        s.waddr = wa; s.wdata = wd; s.n_ticks = n;
        s.tl0 = e_tl0; s.th0 = e_th0; s.tl1 = e_tl1; s.th1 = e_th1;
        s.d_tf0 = f0; s.d_tf1 = f1; s.d_ovf = ov;
        return s;
    endfunction

    step_t steps[15];

    initial begin
        //                 name          tmod   tr0 tr1 wr addr     data  n  tl0    th0    tl1    th1  f0 f1 ov
        steps[0]  = mk("m1_wr_tl0",    8'h01, 0, 0, 1, SFR_TL0, 8'hFE, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        steps[1]  = mk("m1_overflow",  8'h01, 1, 0, 1, SFR_TH0, 8'hFF, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        steps[2]  = mk("m2_wr_th1",    8'h20, 0, 0, 1, SFR_TH1, 8'hF0, 0, 8'h00, 8'h00, 8'h00, 8'hF0, 0, 0, 0);
        steps[3]  = mk("m2_to_ff",     8'h20, 0, 1, 1, SFR_TL1, 8'hFE, 1, 8'h00, 8'h00, 8'hFF, 8'hF0, 0, 0, 0);
        steps[4]  = mk("m2_reload",    8'h20, 0, 1, 0, 8'h00,   8'h00, 1, 8'h00, 8'h00, 8'hF0, 8'hF0, 0, 1, 1);
        steps[5]  = mk("m2_after",     8'h20, 0, 1, 0, 8'h00,   8'h00, 1, 8'h00, 8'h00, 8'hF1, 8'hF0, 0, 0, 0);
        steps[6]  = mk("m0_wr_th0",    8'h00, 0, 0, 1, SFR_TH0, 8'hFF, 0, 8'h00, 8'hFF, 8'hF1, 8'hF0, 0, 0, 0);
        steps[7]  = mk("m0_wrap",      8'h00, 1, 0, 1, SFR_TL0, 8'h1F, 1, 8'h00, 8'h00, 8'hF1, 8'hF0, 1, 0, 0);
        steps[8]  = mk("m0_wr_th0b",   8'h00, 0, 0, 1, SFR_TH0, 8'hFF, 0, 8'h00, 8'hFF, 8'hF1, 8'hF0, 0, 0, 0);
        steps[9]  = mk("m0_hold_75",   8'h00, 1, 0, 1, SFR_TL0, 8'hFF, 1, 8'hE0, 8'h00, 8'hF1, 8'hF0, 1, 0, 0);
        steps[10] = mk("m3_wr_th0",    8'h23, 0, 0, 1, SFR_TH0, 8'hFF, 0, 8'hE0, 8'hFF, 8'hF1, 8'hF0, 0, 0, 0);
        steps[11] = mk("m3_wr_tl1",    8'h23, 0, 0, 1, SFR_TL1, 8'hFE, 0, 8'hE0, 8'hFF, 8'hFE, 8'hF0, 0, 0, 0);
        steps[12] = mk("m3_th0_ovf",   8'h23, 0, 1, 0, 8'h00,   8'h00, 1, 8'hE0, 8'h00, 8'hFF, 8'hF0, 0, 1, 0);
        steps[13] = mk("m3_t1_reload", 8'h23, 0, 1, 0, 8'h00,   8'h00, 1, 8'hE0, 8'h01, 8'hF0, 8'hF0, 0, 0, 1);
        steps[14] = mk("m3_t1_no_tr1", 8'h23, 0, 0, 0, 8'h00,   8'h00, 1, 8'hE0, 8'h01, 8'hF1, 8'hF0, 0, 0, 0);

        data_in = 8'h00; addr = 8'h00; wr_en = 1'b0; wr_bit_en = 1'b0; tmod_data = 8'h00;
        tr0 = 1'b0; tr1 = 1'b0; int0 = 1'b1; int1 = 1'b1; t0 = 1'b1; t1 = 1'b1;
        reset = 1'b1;
        repeat (3) clk1();
        snap();
        push("reset_state", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check_out();
        #2 reset = 1'b0;

        foreach (steps[i]) apply_step(steps[i]);

        // Gated counter: GATE0 with int0 low blocks t0 edges; with int0 high each edge counts
        tr0 = 1'b0; tmod_data = 8'h0D; int0 = 1'b0;
        do_write(SFR_TL0, 8'h00);
        do_write(SFR_TH0, 8'h00);
        snap();
        tr0 = 1'b1;
        for (int i = 0; i < 3; i++) t0_pulse();
        push("gate_low_blocks", 8'h00, 8'h00, 8'hF1, 8'hF0, 0, 0, 0);
        check_out();
        int0 = 1'b1;
        wait_ticks(1);
        for (int i = 0; i < 3; i++) t0_pulse();
        push("gate_high_counts", 8'h03, 8'h00, 8'hF1, 8'hF0, 0, 0, 0);
        check_out();

        // Write on a tick edge wins over the increment
        tmod_data = 8'h01;
        for (int i = 0; i < PS + 1 && (cyc % PS) != PS - 1; i++) clk1();
        snap();
        addr = SFR_TL0; data_in = 8'h55; wr_en = 1'b1;
        clk1();
        wr_en = 1'b0;
        push("write_on_tick", 8'h55, 8'h00, 8'hF1, 8'hF0, 0, 0, 0);
        check_out();
        wait_ticks(1);
        push("after_write_tick", 8'h56, 8'h00, 8'hF1, 8'hF0, 0, 0, 0);
        check_out();

        // Mid-count asynchronous reset, then restart from the next prescaler boundary
        #3 reset = 1'b1;
        #1;
        snap();
        push("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check_out();
        checks++;
        if ({tf0_set, tf1_set, t1_ovf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 000", {tf0_set, tf1_set, t1_ovf});
        end
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        snap();
        for (int i = 0; i < 2 * PS && cyc != PS - 1; i++) clk1();
        push("no_count_before_tick", 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check_out();
        clk1();
        push("first_tick_after_reset", 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check_out();

        clk1();
        checks++;
        if (n_dbl != 0) begin
            errors++;
            $display("FAIL double_pulse: got %0d long pulses, required 0", n_dbl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
